// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: filters per-device join/leave requests and issues them round-robin, one event per clock.
// Define IOT_EVQ_DROP_CNT_EN to add the saturating drop_cnt output.
module iot_event_arbiter #(
  parameter int NDEV = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NDEV-1:0] join_req,
  input  logic [NDEV-1:0] leave_req,
  output logic            change,
  output logic            on_off,
  output logic [IDW-1:0]  dev_id,
  output logic [NDEV-1:0] active_map,
  output logic            pending
`ifdef IOT_EVQ_DROP_CNT_EN
  ,
  output logic [7:0]      drop_cnt
`endif
);
  logic [NDEV-1:0]   r_pend;
  logic [IDW-1:0]    r_rr_ptr;
  logic [NDEV-1:0]   w_eff, w_accept, w_gnt_oh, w_pend_nx;
  logic [2*NDEV-1:0] w_rot;
  logic [IDW:0]      w_off, w_sum;
  logic [IDW-1:0]    w_gnt_idx, w_rr_nx;
  logic              w_gnt_vld;
  assign w_eff    = active_map ^ r_pend;
  assign w_accept = (join_req & ~leave_req & ~w_eff) | (leave_req & ~join_req & w_eff);
  // Rotate pend so bit 0 is rr_ptr; the lowest set bit is the round-robin winner.
  assign w_rot = {r_pend, r_pend} >> r_rr_ptr;
  always_comb begin
    w_gnt_vld = 1'b0;
    w_off     = '0;
    for (int k = NDEV - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_gnt_vld = 1'b1;
        w_off     = (IDW+1)'(k);
      end
    end
  end
  assign w_sum     = {1'b0, r_rr_ptr} + w_off;
  assign w_gnt_idx = (w_sum >= (IDW+1)'(NDEV)) ? IDW'(w_sum - (IDW+1)'(NDEV)) : IDW'(w_sum);
  assign w_rr_nx   = (w_gnt_idx == IDW'(NDEV - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_gnt_oh  = w_gnt_vld ? (NDEV'(1) << w_gnt_idx) : '0;
  // A grant and an accept on the same device cancel in the XOR, leaving it re-armed.
  assign w_pend_nx = r_pend ^ w_gnt_oh ^ w_accept;
  always_ff @(posedge clk) begin
    if (rst) begin
      change     <= 1'b0;
      on_off     <= 1'b0;
      dev_id     <= '0;
      active_map <= '0;
      r_pend     <= '0;
      pending    <= 1'b0;
      r_rr_ptr   <= '0;
    end else begin
      change  <= w_gnt_vld;
      r_pend  <= w_pend_nx;
      pending <= |w_pend_nx;
      if (w_gnt_vld) begin
        dev_id     <= w_gnt_idx;
        on_off     <= ~|(active_map & w_gnt_oh);
        active_map <= active_map ^ w_gnt_oh;
        r_rr_ptr   <= w_rr_nx;
      end
    end
  end
`ifdef IOT_EVQ_DROP_CNT_EN
  logic [7:0] w_drops;
  logic [8:0] w_drop_sum;
  always_comb begin
    w_drops = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_drops = w_drops + ((join_req[i] && leave_req[i]) ? 8'd2 :
                           ((join_req[i] ^ leave_req[i]) && !w_accept[i]) ? 8'd1 : 8'd0);
    end
  end
  assign w_drop_sum = {1'b0, drop_cnt} + {1'b0, w_drops};
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else     drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end
`endif
endmodule
